// File: rtl/cacheline_burst_pkg.sv
// Shared types and sizing for the cache-line to memory-burst adapter.
package cacheline_burst_pkg;

  localparam int S_OFFSET  = 5;
  localparam int S_LINE    = 256;
  localparam int S_BURST   = 64;
  localparam int NUM_BEATS = S_LINE / S_BURST;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adapter_state_t;

  typedef logic [1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(NUM_BEATS - 1);

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Turns 256-bit cache line reads/writes into 4-beat 64-bit memory bursts.
//   state    | meaning
//   IDLE     | waiting for a line request; write has priority over read
//   RD_BURST | read_o high, one beat captured into line_o per resp_i
//   WR_BURST | write_o high, burst_o shows buffered beat k until resp_i
//   DONE     | resp_o pulse for one cycle, then back to IDLE
module cacheline_burst_adapter
  import cacheline_burst_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [S_LINE-1:0]   line_i,
  output logic [S_LINE-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [S_BURST-1:0]  burst_i,
  output logic [S_BURST-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  adapter_state_t    state_q, state_d;
  beat_idx_t         cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [S_LINE-1:0] wbuf_q, wbuf_d;
  logic [S_LINE-1:0] line_q, line_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (write_i) begin
          addr_d  = {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
          wbuf_d  = line_i;
          state_d = WR_BURST;
        end else if (read_i) begin
          addr_d  = {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          line_d[S_BURST*cnt_q +: S_BURST] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Address stays on the bus between bursts; it is zero only until the first request.
  assign address_o = addr_q;
  assign read_o    = (state_q == RD_BURST);
  assign write_o   = (state_q == WR_BURST);
  assign resp_o    = (state_q == DONE);
  assign burst_o   = (state_q == WR_BURST) ? wbuf_q[S_BURST*cnt_q +: S_BURST] : '0;
  assign line_o    = line_q;

endmodule
